// File: rtl/reg16.sv
// General-purpose WIDTH-bit holding register with write enable and asynchronous active-low reset.
// Building block for PC, IR, operand and ALU-result registers in the CPU datapath.
module reg16 #(
    parameter int              WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] I,
    input  logic             Write,
    output logic [WIDTH-1:0] O
);

    // Write acts as a clock enable. Reset takes priority over a coincident write edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            O <= RESET_VALUE;
        end else if (Write) begin
            O <= I;
        end
    end

endmodule

// File: tb/tb_reg16.sv
// Self-checking bench for reg16.
// Uses table-driven write/hold vectors with a scoreboard queue, plus hand-written reset sequences.
module tb_reg16;

    logic        clk;
    logic        rst_n;
    logic [15:0] i_data;
    logic        write;
    logic [15:0] o;

    int tests;
    int fails;

    logic [15:0] exp_q[$];

    typedef struct {
        logic        wr;
        logic [15:0] data;
        logic [15:0] exp_pre;
        logic [15:0] exp_post;
        string       name;
    } vec_t;

    vec_t vecs[$];

    reg16 #(.WIDTH(16), .RESET_VALUE(16'h0000)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .I     (i_data),
        .Write (write),
        .O     (o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
        end
    endtask

    // Drives one edge: checks the value the edge will sample, queues the post-edge expectation, then pops it.
    task automatic apply_stimulus(input logic wr, input logic [15:0] data,
                                  input logic [15:0] exp_pre, input logic [15:0] exp_post,
                                  input string name);
        @(negedge clk);
        check_output({name, "_pre"}, o, exp_pre);
        write  = wr;
        i_data = data;
        exp_q.push_back(exp_post);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s: scoreboard empty, got 0x%04h, expected an entry", name, o);
        end else begin
            check_output(name, o, exp_q.pop_front());
        end
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        rst_n  = 1'b0;
        write  = 1'b1;
        i_data = 16'hBEEF;

        vecs.push_back('{1'b1, 16'hFFFF, 16'h0014, 16'hFFFF, "bnd_ffff"});
        vecs.push_back('{1'b1, 16'h0000, 16'hFFFF, 16'h0000, "bnd_0000"});
        vecs.push_back('{1'b1, 16'hA5A5, 16'h0000, 16'hA5A5, "bnd_a5a5"});
        vecs.push_back('{1'b0, 16'h1111, 16'hA5A5, 16'hA5A5, "bnd_hold"});
        vecs.push_back('{1'b1, 16'h5A5A, 16'hA5A5, 16'h5A5A, "bnd_5a5a"});
        vecs.push_back('{1'b1, 16'hA5A5, 16'h5A5A, 16'hA5A5, "bnd_back"});

        // Reset held with write active and clock running.
        #1;
        check_output("rst_initial", o, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check_output("rst_hold_write", o, 16'h0000);
        end

        // Release reset with Write low: value must stay at reset until a write edge.
        @(negedge clk);
        write = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check_output("post_rst_idle", o, 16'h0000);
        end

        apply_stimulus(1'b1, 16'h0001, 16'h0000, 16'h0001, "basic_write");
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(1'b0, 16'h0002, 16'h0001, 16'h0001, "hold");
        end

        // Incrementing sweep with alternating write and hold edges.
        apply_stimulus(1'b1, 16'h0000, 16'h0001, 16'h0000, "sweep_clear");
        for (int n = 1; n <= 20; n++) begin
            apply_stimulus(1'b1, 16'(n), 16'(n - 1), 16'(n), "sweep_write");
            apply_stimulus(1'b0, 16'(n + 100), 16'(n), 16'(n), "sweep_hold");
        end

        for (int v = 0; v < vecs.size(); v++) begin
            apply_stimulus(vecs[v].wr, vecs[v].data, vecs[v].exp_pre, vecs[v].exp_post, vecs[v].name);
        end

        // Asynchronous reset between edges, then a write edge while still in reset.
        apply_stimulus(1'b1, 16'h1234, 16'hA5A5, 16'h1234, "store_1234");
        write = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_rst_midcycle", o, 16'h0000);
        write  = 1'b1;
        i_data = 16'h7777;
        @(posedge clk);
        #1;
        check_output("rst_beats_write", o, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_output("first_capture", o, 16'h7777);
        write = 1'b0;

        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL scoreboard_drain: got %0d left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
